key_event_conditioner: RTL and testbench
========================================

Name: key_event_conditioner

Overview:
- Front-end stage directly upstream of the car simulator top level; every raw keypad input passes through this block before it reaches the ignition FSM, gear selector, steering or horn logic.
- Per key: synchronises the raw input, debounces it on a slow sample tick, and emits a clean level, one-cycle press/release pulses, a long-press pulse and auto-repeat pulses.
- Also emits a priority-encoded code of the lowest-index key pressed this cycle, so downstream FSMs can consume edges instead of keeping their own prev_key registers.

Parameters:
N_KEYS, 12, number of key inputs; index 0..11 = KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_SHARP.
DB_TICKS, 20, consecutive differing samples required to flip a debounced level; legal range 1..255.
LONG_TICKS, 1000, sample ticks of continuous hold before key_long fires; must be greater than DB_TICKS.
REPEAT_TICKS, 200, sample ticks between key_repeat pulses after key_long fires.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tick_sample  in  1  one-cycle sample strobe, nominal 1 kHz.
key_raw  in  N_KEYS  asynchronous raw key levels, 1 = pressed.
key_level  out  N_KEYS  debounced level.
key_press  out  N_KEYS  one-cycle pulse on each debounced 0->1 transition.
key_release  out  N_KEYS  one-cycle pulse on each debounced 1->0 transition.
key_long  out  N_KEYS  one-cycle pulse when hold time reaches LONG_TICKS.
key_repeat  out  N_KEYS  one-cycle pulse every REPEAT_TICKS of hold after key_long.
press_valid  out  1  high in any cycle where key_press is non-zero.
press_code  out  4  index of the lowest-numbered bit set in key_press; 0 when press_valid is 0.

Behaviour:
- Reset: only clk and rst are used; rst is sampled on rising clk. While rst is high, all outputs, synchroniser flops, debounce counters and hold counters are 0.
- Synchroniser: two flops per key, updated every clk regardless of tick_sample; sync = the second flop.
- Debounce (per key; updates only in cycles where tick_sample = 1):
  - sync == key_level: db_cnt <= 0.
  - sync != key_level and db_cnt == DB_TICKS-1: key_level toggles, db_cnt <= 0.
  - otherwise: db_cnt increments.
  - Any sample that matches key_level restarts the count, so a bounce shorter than DB_TICKS samples never changes key_level.
- Edge pulses:
  - key_press[i] and key_release[i] are registered in the same clk edge that updates key_level[i].
  - Each is high for exactly one clk; all pulse outputs are 0 in every cycle where tick_sample = 0.
- Hold counter (per key; width clog2(LONG_TICKS+REPEAT_TICKS)+1):
  - Cleared while key_level = 0.
  - On the tick that sets key_level, hold_cnt <= 0.
  - On each later tick with key_level = 1, hold_cnt increments.
  - key_long[i] pulses on the tick where hold_cnt becomes LONG_TICKS.
  - key_repeat[i] pulses each time hold_cnt becomes LONG_TICKS + k*REPEAT_TICKS, k >= 1.
  - Implement as a phase counter: after LONG_TICKS is reached, a second counter wraps 0..REPEAT_TICKS-1, so holds of any length never overflow.
- Release during the long or repeat phase:
  - key_release pulses, and hold and phase counters clear on the same tick.
  - No key_long or key_repeat pulse on the release tick.
- Simultaneous events:
  - Keys are independent; several bits of any pulse vector may be high in the same cycle.
  - press_code encodes the lowest set index of key_press; press_valid = |key_press.
  - press_code and press_valid are combinational from the registered key_press (zero added latency).
- Latency: a clean raw 0->1 edge produces key_press after 2 clk (synchroniser) plus DB_TICKS sample ticks; the pulse appears on the clk edge of the DB_TICKS-th qualifying tick.
- Reset mid-operation:
  - All state clears.
  - A key held through reset re-debounces from key_level = 0 and produces a fresh key_press DB_TICKS ticks after reset is released; no key_release is emitted for the pre-reset press.
- tick_sample held high continuously is legal: debounce then runs per clk.

Test Plan:
(Bench parameters: DB_TICKS = 4, LONG_TICKS = 10, REPEAT_TICKS = 3; tick_sample every 5 clk.)
1. key_raw[3] held at 1 from t0 -> key_level[3] rises and key_press[3] pulses for 1 clk on the 4th tick after sync goes high; press_valid = 1 and press_code = 3 in that cycle only.
2. key_raw[0] toggles 1,1,1,0,1,1,1,0 across consecutive ticks -> key_level[0] stays 0 and no pulses occur. Then held high for 4 ticks -> exactly one key_press[0].
3. key_raw[10] held for 20 ticks after key_level rises -> key_long[10] at hold tick 10; key_repeat[10] at hold ticks 13, 16 and 19. Releasing the raw input -> key_release[10] after 4 more ticks, with no repeat pulse on that tick.
4. key_raw[9] and key_raw[2] rise on the same clk -> key_press = 0x204 in one cycle, press_code = 2, press_valid = 1.
5. Key 5 held; rst asserted for 3 clk mid-debounce and again after key_level[5] = 1 -> all outputs 0 during reset, no key_release emitted, and a new key_press[5] exactly 4 ticks after rst deasserts.
6. tick_sample tied high, key_raw[11] held -> key_press[11] at clk 2 + 4; key_long[11] 10 clk later.

Source files
------------

// File: rtl/key_event_conditioner_if.sv
// Keypad bus between the raw key inputs and the conditioned event outputs.
// The conditioner takes the slave side; whoever drives the keys takes the master side.
interface key_event_conditioner_if #(
  parameter int N_KEYS = 12
);
  logic              tick_sample;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;
  logic              press_valid;
  logic [3:0]        press_code;

  modport master (
    output tick_sample, key_raw,
    input  key_level, key_press, key_release, key_long, key_repeat,
    input  press_valid, press_code
  );

  modport slave (
    input  tick_sample, key_raw,
    output key_level, key_press, key_release, key_long, key_repeat,
    output press_valid, press_code
  );
endinterface

// File: rtl/key_event_conditioner.sv
// Per-key synchroniser, debouncer and hold timer for the keypad.
// Emits clean levels, edge pulses, long-press and auto-repeat pulses, plus a press code.
module key_event_conditioner #(
  parameter int N_KEYS       = 12,
  parameter int DB_TICKS     = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input logic clk,
  input logic rst,
  key_event_conditioner_if.slave bus
);
  localparam int HOLD_W = $clog2(LONG_TICKS + REPEAT_TICKS) + 1;
  localparam int REP_W  = $clog2(REPEAT_TICKS) + 1;
  localparam logic [7:0]        DB_LAST   = 8'(DB_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_long;
  logic [N_KEYS-1:0] r_repeat;
  logic [N_KEYS-1:0] r_longDone;
  logic [7:0]        r_dbCnt   [N_KEYS];
  logic [HOLD_W-1:0] r_holdCnt [N_KEYS];
  logic [REP_W-1:0]  r_repCnt  [N_KEYS];
  logic [3:0]        w_pressCode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_level    <= '0;
      r_press    <= '0;
      r_release  <= '0;
      r_long     <= '0;
      r_repeat   <= '0;
      r_longDone <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_dbCnt[i]   <= '0;
        r_holdCnt[i] <= '0;
        r_repCnt[i]  <= '0;
      end
    end else begin
      r_sync1   <= bus.key_raw;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_repeat  <= '0;
      if (bus.tick_sample) begin
        for (int i = 0; i < N_KEYS; i++) begin
          if (r_sync2[i] != r_level[i] && r_dbCnt[i] == DB_LAST) begin
            r_level[i]    <= ~r_level[i];
            r_dbCnt[i]    <= '0;
            r_holdCnt[i]  <= '0;
            r_repCnt[i]   <= '0;
            r_longDone[i] <= 1'b0;
            if (r_level[i]) r_release[i] <= 1'b1;
            else            r_press[i]   <= 1'b1;
          end else begin
            r_dbCnt[i] <= (r_sync2[i] == r_level[i]) ? 8'd0 : r_dbCnt[i] + 8'd1;
            // Hold count stops at LONG_TICKS; the wrapping phase counter takes over from there.
            if (!r_level[i]) begin
              r_holdCnt[i]  <= '0;
              r_repCnt[i]   <= '0;
              r_longDone[i] <= 1'b0;
            end else if (!r_longDone[i]) begin
              r_holdCnt[i] <= r_holdCnt[i] + HOLD_W'(1);
              if (r_holdCnt[i] == LONG_LAST) begin
                r_long[i]     <= 1'b1;
                r_longDone[i] <= 1'b1;
                r_repCnt[i]   <= '0;
              end
            end else if (r_repCnt[i] == REP_LAST) begin
              r_repeat[i] <= 1'b1;
              r_repCnt[i] <= '0;
            end else begin
              r_repCnt[i] <= r_repCnt[i] + REP_W'(1);
            end
          end
        end
      end
    end
  end

  // Scan downward so the lowest pressed index is the one left standing.
  always_comb begin
    w_pressCode = 4'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (r_press[i]) w_pressCode = 4'(i);
    end
  end

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_long    = r_long;
  assign bus.key_repeat  = r_repeat;
  assign bus.press_valid = |r_press;
  assign bus.press_code  = w_pressCode;
endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner: directed scenarios then random key activity,
// compared every clock against a tick-timestamp reference model.
module tb_key_event_conditioner;
  localparam int N    = 12;
  localparam int DB   = 4;
  localparam int LONG = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_event_conditioner_if #(.N_KEYS(N)) bus ();

  key_event_conditioner #(
    .N_KEYS(N), .DB_TICKS(DB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] rawD1, rawD2, curRaw;
  logic [N-1:0] expLevel, expPress, expRelease, expLong, expRepeat;
  int tickIdx;
  int lastMatch [N];
  int riseTick  [N];
  int checks = 0;
  int errors = 0;
  bit saw204;
  int key0Presses;
  int key5Releases;

  // Model: a level flips once DB consecutive ticks have all disagreed with it,
  // measured as tick-index distance from the last agreeing tick.
  task automatic modelEdge();
    logic [N-1:0] s;
    int h;
    expPress = '0; expRelease = '0; expLong = '0; expRepeat = '0;
    if (rst) begin
      rawD1 = '0; rawD2 = '0; expLevel = '0;
      for (int i = 0; i < N; i++) begin
        lastMatch[i] = tickIdx;
        riseTick[i]  = tickIdx;
      end
    end else begin
      s = rawD2;
      rawD2 = rawD1;
      rawD1 = bus.key_raw;
      if (bus.tick_sample) begin
        tickIdx++;
        for (int i = 0; i < N; i++) begin
          if (s[i] == expLevel[i]) begin
            lastMatch[i] = tickIdx;
          end else if (tickIdx - lastMatch[i] == DB) begin
            expLevel[i] = ~expLevel[i];
            lastMatch[i] = tickIdx;
            if (expLevel[i]) begin
              expPress[i] = 1'b1;
              riseTick[i] = tickIdx;
            end else begin
              expRelease[i] = 1'b1;
            end
          end
          if (expLevel[i] && !expPress[i]) begin
            h = tickIdx - riseTick[i];
            if (h == LONG) expLong[i] = 1'b1;
            if (h > LONG && (h - LONG) % REP == 0) expRepeat[i] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [3:0] lowestIndex(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic checkOutput();
    checks += 4;
    assert (bus.key_level === expLevel)
      else begin errors++; $error("[TB] FAIL level observed=%h expected=%h", bus.key_level, expLevel); end
    assert ({bus.key_press, bus.key_release, bus.key_long, bus.key_repeat} ===
            {expPress, expRelease, expLong, expRepeat})
      else begin
        errors++;
        $error("[TB] FAIL pulses press/rel/long/rep observed=%h/%h/%h/%h expected=%h/%h/%h/%h",
               bus.key_press, bus.key_release, bus.key_long, bus.key_repeat,
               expPress, expRelease, expLong, expRepeat);
      end
    assert (bus.press_valid === (|expPress))
      else begin errors++; $error("[TB] FAIL press_valid observed=%b expected=%b", bus.press_valid, |expPress); end
    assert (bus.press_code === lowestIndex(expPress))
      else begin errors++; $error("[TB] FAIL press_code observed=%0d expected=%0d", bus.press_code, lowestIndex(expPress)); end
    if (bus.key_press === 12'h204 && bus.press_code === 4'd2 && bus.press_valid === 1'b1) saw204 = 1'b1;
    if (bus.key_press[0] === 1'b1) key0Presses++;
    if (bus.key_release[5] === 1'b1) key5Releases++;
  endtask

  task automatic applyStimulus(input logic [N-1:0] raw, input logic tk, input logic rs);
    @(negedge clk);
    bus.key_raw     = raw;
    bus.tick_sample = tk;
    rst             = rs;
    curRaw          = raw;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic runTicks(input logic [N-1:0] raw, input int n);
    repeat (n) begin
      applyStimulus(raw, 1'b1, 1'b0);
      repeat (4) applyStimulus(raw, 1'b0, 1'b0);
    end
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(curRaw, 1'b0, 1'b1);
  endtask

  initial begin
    int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    logic [N-1:0] raw;
    rawD1 = '0; rawD2 = '0; curRaw = '0; tickIdx = 0;
    expLevel = '0; saw204 = 1'b0; key0Presses = 0; key5Releases = 0;
    bus.key_raw = '0; bus.tick_sample = 1'b0; rst = 1'b1;
    doReset(3);

    runTicks(12'h008, 8);
    for (int k = 0; k < 8; k++) runTicks(12'h008 | 12'(pat[k]), 1);
    checks++;
    assert (key0Presses == 0)
      else begin errors++; $error("[TB] FAIL bounce_presses observed=%0d expected=0", key0Presses); end
    runTicks(12'h009, 6);
    checks++;
    assert (key0Presses == 1)
      else begin errors++; $error("[TB] FAIL clean_presses observed=%0d expected=1", key0Presses); end

    runTicks(12'h400, 26);
    runTicks(12'h000, 6);

    runTicks(12'h204, 6);
    checks++;
    assert (saw204 == 1'b1)
      else begin errors++; $error("[TB] FAIL dual_press observed=%b expected=1", saw204); end
    runTicks(12'h000, 6);

    key5Releases = 0;
    runTicks(12'h020, 2);
    doReset(3);
    runTicks(12'h020, 6);
    doReset(3);
    runTicks(12'h020, 6);
    checks++;
    assert (key5Releases == 0)
      else begin errors++; $error("[TB] FAIL reset_release observed=%0d expected=0", key5Releases); end
    doReset(2);

    repeat (30) applyStimulus(12'h800, 1'b1, 1'b0);
    doReset(2);

    raw = '0;
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) raw[$urandom_range(0, N - 1)] ^= 1'b1;
      applyStimulus(raw, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
